// File: rtl/snake_pkg.sv
// Definitions shared by the game-logic frame producer and the LED matrix scanner:
// matrix geometry, pixel polarity and the row-major frame bit index.
package snake_pkg;
  localparam int   MATRIX_DIM = 8;
  localparam logic LED_ON     = 1'b0;
  localparam logic LED_OFF    = 1'b1;

  function automatic int idx(input int r, input int c);
    return MATRIX_DIM * r + c;
  endfunction
endpackage

// File: rtl/led_matrix_scan_if.sv
// Frame/control bundle between the game logic (master) and the LED matrix scanner (slave).
interface led_matrix_scan_if;
  import snake_pkg::*;

  logic [MATRIX_DIM*MATRIX_DIM-1:0] frame;
  logic                             freeze;
  logic [3:0]                       brightness;
  logic [MATRIX_DIM-1:0]            row_en;
  logic [MATRIX_DIM-1:0]            col_n;
  logic                             frame_start;

  modport master (output frame, freeze, brightness, input  row_en, col_n, frame_start);
  modport slave  (input  frame, freeze, brightness, output row_en, col_n, frame_start);
endinterface

// File: rtl/led_matrix_scan_timer.sv
// Row dwell timing: cnt/row scan counters, per-row brightness sample and the PWM phase.
module scan_timer #(
  parameter int ROW_CYCLES   = 5000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic       system_clk,
  input  logic       rst,
  input  logic [3:0] brightness,
  output logic [2:0] row,
  output logic       blank,
  output logic       pwm_on,
  output logic       boundary
);
  localparam logic [15:0] CNT_LAST   = 16'(ROW_CYCLES - 1);
  localparam logic [15:0] BLANK_END  = 16'(BLANK_CYCLES);
  localparam logic [15:0] BRL_SAMPLE = 16'(BLANK_CYCLES - 1);

  logic [15:0] cnt;
  logic [3:0]  pwm;
  logic [3:0]  brl;

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      row <= '0;
      pwm <= '0;
      brl <= '0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        row <= row + 3'd1;
      end else begin
        cnt <= cnt + 16'd1;
      end
      // Last blank cycle: freeze brightness for the coming on-window and zero pwm
      // so that pwm reads 0 on the first on cycle.
      if (cnt == BRL_SAMPLE) begin
        pwm <= '0;
        brl <= brightness;
      end else if (!blank) begin
        pwm <= pwm + 4'd1;
      end
    end
  end

  assign blank    = (cnt < BLANK_END);
  assign pwm_on   = !blank && (pwm <= brl);
  assign boundary = (row == 3'd0) && (cnt == 16'd0);
endmodule

// File: rtl/led_matrix_scan.sv
// Row-multiplexed 8x8 LED driver: tear-free shadow frame loaded at frame boundaries,
// per-row blanking and 16-level PWM, all outputs registered.
module led_matrix_scan
  import snake_pkg::*;
#(
  parameter int ROW_CYCLES     = 5000,
  parameter int BLANK_CYCLES   = 50,
  // Clearing this relaxes the check to the bare counting limits, for short-dwell sims.
  parameter bit FULL_PWM_CHECK = 1'b1
) (
  input  logic            system_clk,
  input  logic            rst,
  led_matrix_scan_if.slave bus
);
  localparam logic [MATRIX_DIM-1:0] ROW0_EN = MATRIX_DIM'(1);
  localparam logic [MATRIX_DIM-1:0] ALL_OFF = {MATRIX_DIM{LED_OFF}};

  localparam bit BASIC_OK = (ROW_CYCLES >= 2) && (ROW_CYCLES <= 65535) &&
                            (BLANK_CYCLES >= 1) && (BLANK_CYCLES < ROW_CYCLES);
  localparam bit FULL_OK  = (ROW_CYCLES >= 32) && (BLANK_CYCLES <= ROW_CYCLES - 17);

  if (!BASIC_OK || (FULL_PWM_CHECK && !FULL_OK)) begin : g_bad_params
    $error("led_matrix_scan: illegal ROW_CYCLES=%0d / BLANK_CYCLES=%0d", ROW_CYCLES, BLANK_CYCLES);
  end

  logic [2:0] row;
  logic       blank;
  logic       pwm_on;
  logic       boundary;

  logic [MATRIX_DIM*MATRIX_DIM-1:0] shadow;

  scan_timer #(
    .ROW_CYCLES  (ROW_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_timer (
    .system_clk(system_clk),
    .rst       (rst),
    .brightness(bus.brightness),
    .row       (row),
    .blank     (blank),
    .pwm_on    (pwm_on),
    .boundary  (boundary)
  );

  always_ff @(posedge system_clk or posedge rst) begin
    if (rst) begin
      shadow          <= '1;
      bus.row_en      <= '0;
      bus.col_n       <= ALL_OFF;
      bus.frame_start <= 1'b0;
    end else begin
      if (boundary && !bus.freeze)
        shadow <= bus.frame;
      bus.frame_start <= boundary;
      if (blank) begin
        bus.row_en <= '0;
        bus.col_n  <= ALL_OFF;
      end else begin
        bus.row_en <= ROW0_EN << row;
        bus.col_n  <= pwm_on ? shadow[idx(int'(row), 0) +: MATRIX_DIM] : ALL_OFF;
      end
    end
  end
endmodule
